// File: rtl/ls_pwr_pkg.sv
// Shared definitions for the level-shifter power sequencer.
//   ls_seq_state_e        : sequencer state encoding (also exported on state_o)
//   LS_SETTLE_CYCLES_DEF  : default shifter settle time in cycles
//   LS_TIMEOUT_CYCLES_DEF : default supply-good wait limit in cycles
package ls_pwr_pkg;

    typedef enum logic [2:0] {
        LS_OFF         = 3'd0,
        LS_WAIT_SUPPLY = 3'd1,
        LS_SETTLE      = 3'd2,
        LS_ACTIVE      = 3'd3,
        LS_DRAIN       = 3'd4,
        LS_ISOLATE     = 3'd5,
        LS_ERROR       = 3'd6
    } ls_seq_state_e;

    localparam int LS_SETTLE_CYCLES_DEF  = 8;
    localparam int LS_TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/ls_pwr_seq_sync_2ff.sv
// One-bit two-flop synchronizer, asynchronous active-low reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ls_pwr_seq.sv
// Power sequencer and data-launch stage in front of the enabled
// high-to-low level shifter. Runs in the always-on high domain.
//   clk, rst_n              : clock, asynchronous active-low reset
//   pwr_on_req, pwr_off_req : level requests to bring the crossing up/down
//   vdd_*_good_async        : raw supply-good flags, synchronized here
//   data_in/valid/ready     : payload handshake from the high domain
//   ls_en, ls_data          : shifter bank enable and registered payload
//   iso_en                  : isolation clamp (1 = clamped)
//   pwr_ack, seq_err        : crossing active, sticky error
//   state_o                 : current state, for debug
module ls_pwr_seq
    import ls_pwr_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SETTLE_CYCLES  = LS_SETTLE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = LS_TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwr_on_req,
    input  logic             pwr_off_req,
    input  logic             vdd_high_good_async,
    input  logic             vdd_low_good_async,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ls_en,
    output logic [WIDTH-1:0] ls_data,
    output logic             iso_en,
    output logic             pwr_ack,
    output logic             seq_err,
    output logic [2:0]       state_o
);

    localparam int TMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX);

    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic vh_sync, vl_sync, good;

    sync_2ff u_sync_high (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vdd_high_good_async),
        .q     (vh_sync)
    );

    sync_2ff u_sync_low (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vdd_low_good_async),
        .q     (vl_sync)
    );

    assign good = vh_sync & vl_sync;

    ls_seq_state_e   state, state_nxt;
    logic [TW-1:0]   timer;

    logic             ls_en_nxt, iso_en_nxt, pwr_ack_nxt, data_ready_nxt, seq_err_nxt;
    logic [WIDTH-1:0] ls_data_nxt;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            LS_OFF:
                if (pwr_on_req && !pwr_off_req) state_nxt = LS_WAIT_SUPPLY;
            LS_WAIT_SUPPLY:
                if (pwr_off_req)                state_nxt = LS_OFF;
                else if (good)                  state_nxt = LS_SETTLE;
                else if (timer == TIMEOUT_LAST) state_nxt = LS_ERROR;
            LS_SETTLE:
                if (!good)                      state_nxt = LS_WAIT_SUPPLY;
                else if (timer == SETTLE_LAST)  state_nxt = LS_ACTIVE;
            LS_ACTIVE:
                if (!good)                      state_nxt = LS_ERROR;
                else if (pwr_off_req)           state_nxt = LS_DRAIN;
            LS_DRAIN:
                state_nxt = LS_ISOLATE;
            LS_ISOLATE:
                if (timer == SETTLE_LAST)       state_nxt = LS_OFF;
            LS_ERROR:
                if (pwr_off_req)                state_nxt = LS_OFF;
            default:
                state_nxt = LS_OFF;
        endcase
    end

    // Outputs are decoded from the state being entered and then registered,
    // so every output changes on the same edge as state_o.
    always_comb begin
        ls_en_nxt      = 1'b0;
        iso_en_nxt     = 1'b1;
        pwr_ack_nxt    = 1'b0;
        data_ready_nxt = 1'b0;
        seq_err_nxt    = 1'b0;
        case (state_nxt)
            LS_SETTLE, LS_ISOLATE: ls_en_nxt = 1'b1;
            LS_ACTIVE: begin
                ls_en_nxt      = 1'b1;
                iso_en_nxt     = 1'b0;
                pwr_ack_nxt    = 1'b1;
                data_ready_nxt = 1'b1;
            end
            LS_DRAIN: begin
                ls_en_nxt   = 1'b1;
                iso_en_nxt  = 1'b0;
                pwr_ack_nxt = 1'b1;
            end
            LS_ERROR: seq_err_nxt = 1'b1;
            default: ;
        endcase

        // A beat offered on the last ACTIVE cycle (off request) is still taken,
        // since data_ready was high when it was presented.
        ls_data_nxt = ls_data;
        if (state_nxt == LS_OFF || state_nxt == LS_ERROR)
            ls_data_nxt = '0;
        else if (data_ready && data_valid)
            ls_data_nxt = data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LS_OFF;
            timer      <= '0;
            ls_en      <= 1'b0;
            iso_en     <= 1'b1;
            pwr_ack    <= 1'b0;
            data_ready <= 1'b0;
            seq_err    <= 1'b0;
            ls_data    <= '0;
        end else begin
            state      <= state_nxt;
            ls_en      <= ls_en_nxt;
            iso_en     <= iso_en_nxt;
            pwr_ack    <= pwr_ack_nxt;
            data_ready <= data_ready_nxt;
            seq_err    <= seq_err_nxt;
            ls_data    <= ls_data_nxt;
            // Shared timer: restarts on any state change, saturates otherwise.
            if (state_nxt != state)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + 1'b1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_ls_pwr_seq.sv
module tb_ls_pwr_seq;

    localparam int W = 8;
    localparam int S = 8;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         on = 1'b0, off = 1'b0, vh = 1'b1, vl = 1'b1, dv = 1'b0;
    logic [W-1:0] din = '0;
    logic         data_ready, ls_en, iso_en, pwr_ack, seq_err;
    logic [W-1:0] ls_data;
    logic [2:0]   state_o;

    int n_tests = 0;
    int n_fail  = 0;

    ls_pwr_seq #(.WIDTH(W), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pwr_on_req          (on),
        .pwr_off_req         (off),
        .vdd_high_good_async (vh),
        .vdd_low_good_async  (vl),
        .data_in             (din),
        .data_valid          (dv),
        .data_ready          (data_ready),
        .ls_en               (ls_en),
        .ls_data             (ls_data),
        .iso_en              (iso_en),
        .pwr_ack             (pwr_ack),
        .seq_err             (seq_err),
        .state_o             (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase numbers follow the documented debug encoding of state_o.
    int           m_ph;      // phase
    int           m_age;     // cycles spent in current phase
    bit [1:0]     m_h, m_l;  // supply history, [1] = what the sequencer sees
    logic [W-1:0] m_data;

    task automatic m_reset();
        m_ph = 0; m_age = 0; m_h = '0; m_l = '0; m_data = '0;
    endtask

    task automatic m_step();
        bit good;
        int np;
        good = m_h[1] & m_l[1];
        np   = m_ph;
        if (m_ph == 0) begin
            if (on && !off) np = 1;
        end else if (m_ph == 1) begin
            if (off) np = 0;
            else if (good) np = 2;
            else if (m_age == T-1) np = 6;
        end else if (m_ph == 2) begin
            if (!good) np = 1;
            else if (m_age == S-1) np = 3;
        end else if (m_ph == 3) begin
            if (!good) np = 6;
            else if (off) np = 4;
        end else if (m_ph == 4) begin
            np = 5;
        end else if (m_ph == 5) begin
            if (m_age == S-1) np = 0;
        end else if (m_ph == 6) begin
            if (off) np = 0;
        end
        if (np == 0 || np == 6) m_data = '0;
        else if (m_ph == 3 && dv) m_data = din;
        m_age = (np == m_ph) ? m_age + 1 : 0;
        m_ph  = np;
        m_h   = {m_h[0], vh};
        m_l   = {m_l[0], vl};
    endtask

    task automatic m_chk();
        chk("m_state",   32'(state_o),    32'(m_ph));
        chk("m_ls_en",   32'(ls_en),      32'(m_ph inside {2, 3, 4, 5}));
        chk("m_iso_en",  32'(iso_en),     32'(!(m_ph inside {3, 4})));
        chk("m_pwr_ack", 32'(pwr_ack),    32'(m_ph inside {3, 4}));
        chk("m_ready",   32'(data_ready), 32'(m_ph == 3));
        chk("m_seq_err", 32'(seq_err),    32'(m_ph == 6));
        chk("m_ls_data", 32'(ls_data),    32'(m_data));
    endtask

    // Inputs are changed at the falling edge; outputs checked 1 after rising.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) m_step();
        #1;
        m_chk();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        #1;
        m_chk();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input int tgt, input int bound);
        int k;
        k = 0;
        while (state_o !== 3'(tgt) && k < bound) begin
            cycle();
            k++;
        end
        chk("wait_state", 32'(state_o), 32'(tgt));
    endtask

    // ---------------- table of vectors ----------------
    typedef struct {
        logic         on, off, dv;
        logic [W-1:0] din;
        int           st;
        logic         ls, iso, ack, rdy;
        logic [W-1:0] data;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic on_i, logic off_i, logic dv_i, logic [W-1:0] din_i,
                                int st, logic ls_i, logic iso_i, logic ack_i, logic rdy_i,
                                logic [W-1:0] data_i);
        vec_t v;
        v.on = on_i; v.off = off_i; v.dv = dv_i; v.din = din_i;
        v.st = st; v.ls = ls_i; v.iso = iso_i; v.ack = ack_i; v.rdy = rdy_i; v.data = data_i;
        return v;
    endfunction

    initial begin
        int ws, sc, n;

        // Power-up / data / power-down, supplies high through reset.
        tbl[0] = mk(1, 0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00);
        tbl[1] = mk(0, 0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00);
        for (int i = 2; i <= 9; i++) tbl[i] = mk(0, 0, 0, 8'h00, 2, 1, 1, 0, 0, 8'h00);
        tbl[10] = mk(0, 0, 1, 8'h77, 3, 1, 0, 1, 1, 8'h00); // offered in SETTLE: ignored
        tbl[11] = mk(0, 0, 1, 8'hA5, 3, 1, 0, 1, 1, 8'hA5);
        tbl[12] = mk(0, 0, 1, 8'h3C, 3, 1, 0, 1, 1, 8'h3C);
        tbl[13] = mk(0, 0, 0, 8'hEE, 3, 1, 0, 1, 1, 8'h3C);
        tbl[14] = mk(1, 1, 0, 8'h00, 4, 1, 0, 1, 0, 8'h3C); // off beats on
        tbl[15] = mk(0, 0, 1, 8'hFF, 5, 1, 1, 0, 0, 8'h3C); // DRAIN: not accepted
        for (int i = 16; i <= 22; i++) tbl[i] = mk(0, 0, 0, 8'h00, 5, 1, 1, 0, 0, 8'h3C);
        tbl[23] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00);

        @(negedge clk);
        do_reset();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_iso",   32'(iso_en),  1);

        for (int i = 0; i < 24; i++) begin
            on = tbl[i].on; off = tbl[i].off; dv = tbl[i].dv; din = tbl[i].din;
            cycle();
            chk($sformatf("tbl%0d_state", i), 32'(state_o),    32'(tbl[i].st));
            chk($sformatf("tbl%0d_ls_en", i), 32'(ls_en),      32'(tbl[i].ls));
            chk($sformatf("tbl%0d_iso", i),   32'(iso_en),     32'(tbl[i].iso));
            chk($sformatf("tbl%0d_ack", i),   32'(pwr_ack),    32'(tbl[i].ack));
            chk($sformatf("tbl%0d_rdy", i),   32'(data_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_data", i),  32'(ls_data),    32'(tbl[i].data));
        end
        on = 0; off = 0; dv = 0;

        // Timeout: low supply absent, WAIT_SUPPLY lasts exactly T cycles.
        vl = 0;
        repeat (3) cycle();
        on = 1;
        cycle();
        on = 0;
        ws = (state_o == 3'd1) ? 1 : 0;
        for (int k = 0; k < 40 && state_o == 3'd1; k++) begin
            cycle();
            if (state_o == 3'd1) ws++;
        end
        chk("timeout_len", 32'(ws), 32'(T));
        chk("timeout_state", 32'(state_o), 6);
        chk("timeout_err", 32'(seq_err), 1);
        on = 1;
        repeat (3) cycle();
        chk("err_ignores_on", 32'(state_o), 6);
        on = 0; off = 1;
        cycle();
        off = 0;
        chk("err_clear_state", 32'(state_o), 0);
        chk("err_clear_flag", 32'(seq_err), 0);

        // Supply glitch at settle count 4.
        vl = 1;
        repeat (3) cycle();
        on = 1;
        cycle();
        on = 0;
        wait_state(2, 20);
        repeat (4) cycle();
        vl = 0;
        repeat (3) cycle();
        vl = 1;
        chk("glitch_state", 32'(state_o), 1);
        chk("glitch_ls_en", 32'(ls_en), 0);
        wait_state(2, 20);
        sc = 1;
        for (int k = 0; k < 20 && state_o == 3'd2; k++) begin
            cycle();
            if (state_o == 3'd2) sc++;
        end
        chk("resettle_len", 32'(sc), 32'(S));
        chk("resettle_active", 32'(state_o), 3);

        // Supply loss in ACTIVE.
        dv = 1; din = 8'h5A;
        cycle();
        dv = 0;
        chk("loss_pre_data", 32'(ls_data), 32'h5A);
        vh = 0;
        n = 0;
        for (int k = 0; k < 10 && state_o != 3'd6; k++) begin
            cycle();
            n++;
        end
        chk("loss_latency", 32'(n), 3);
        chk("loss_iso", 32'(iso_en), 1);
        chk("loss_data", 32'(ls_data), 0);
        vh = 1; off = 1;
        cycle();
        off = 0;
        chk("loss_off", 32'(state_o), 0);
        repeat (3) cycle();

        // Asynchronous reset in the middle of SETTLE.
        on = 1;
        cycle();
        on = 0;
        wait_state(2, 20);
        cycle();
        #2;
        rst_n = 0;
        #1;
        chk("arst_iso", 32'(iso_en), 1);
        chk("arst_ls_en", 32'(ls_en), 0);
        chk("arst_state", 32'(state_o), 0);
        m_reset();
        @(negedge clk);
        cycle();
        rst_n = 1;

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            on  = ($urandom % 4) == 0;
            off = ($urandom % 12) == 0;
            vh  = ($urandom % 30) != 0;
            vl  = ($urandom % 30) != 0;
            dv  = $urandom % 2;
            din = W'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ls_pwr_seq.md
Name: ls_pwr_seq

Overview:
- Sequencer and data-launch stage directly upstream of the enabled high-to-low level shifter.
- Sequences power-up and power-down of the low-voltage domain crossing: shifter enable, isolation clamp and supply-good qualification.
- Registers the high-domain data bus it drives into the shifter.
- Lives in the always-on high-voltage domain.

Parameters:
WIDTH, 8, data bus width passed to the shifter bank
SETTLE_CYCLES, 8, cycles the shifter is enabled before isolation releases, and held after isolation asserts; must be >=1
TIMEOUT_CYCLES, 256, maximum cycles to wait for both supplies good before error; must be >=2

Ports:
clk  in  1  single clock, always-on domain
rst_n  in  1  asynchronous active-low reset
pwr_on_req  in  1  level request to bring the crossing up
pwr_off_req  in  1  level request to take the crossing down
vdd_high_good_async  in  1  high supply good, asynchronous
vdd_low_good_async  in  1  low supply good, asynchronous
data_in  in  WIDTH  payload from the high domain
data_valid  in  1  payload valid
data_ready  out  1  stage accepts payload
ls_en  out  1  shifter bank enable
ls_data  out  WIDTH  registered payload to the shifter bank
iso_en  out  1  isolation clamp enable, 1 = clamped
pwr_ack  out  1  crossing active
seq_err  out  1  sticky supply or timeout error
state_o  out  3  current state encoding, for debug

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All outputs are registered.
- Reset values:
  - state = OFF
  - iso_en = 1; ls_en = 0; ls_data = 0
  - data_ready = 0; pwr_ack = 0; seq_err = 0
  - synchronizers cleared to 0
- Synchronizers: each supply-good input passes through a 2-flop synchronizer. good = AND of both synced values. Supply edge to internal view: 2 cycles.
- One shared timer counter, cleared on every state change.
- State encoding: OFF=0, WAIT_SUPPLY=1, SETTLE=2, ACTIVE=3, DRAIN=4, ISOLATE=5, ERROR=6.
- OFF:
  - Outputs: iso_en=1, ls_en=0, ls_data=0.
  - pwr_on_req & !pwr_off_req -> WAIT_SUPPLY.
- WAIT_SUPPLY:
  - good -> SETTLE.
  - Otherwise, timer == TIMEOUT_CYCLES-1 -> ERROR.
  - pwr_off_req -> OFF. This has priority.
- SETTLE:
  - Outputs: ls_en=1, iso_en=1.
  - !good -> WAIT_SUPPLY, timer restarts; ls_en drops next cycle.
  - timer == SETTLE_CYCLES-1 -> ACTIVE.
- ACTIVE:
  - Outputs: iso_en=0, pwr_ack=1, data_ready=1.
  - data_valid & data_ready -> ls_data <= data_in. Latency is 1 cycle; a new beat is accepted every cycle.
  - !good -> ERROR. This has priority over pwr_off_req.
  - pwr_off_req -> DRAIN. Off wins over a concurrent on request.
- DRAIN:
  - One cycle. data_ready=0, ls_data held, pwr_ack=1.
  - -> ISOLATE.
- ISOLATE:
  - Outputs: iso_en=1, ls_en=1, ls_data held, pwr_ack=0.
  - timer == SETTLE_CYCLES-1 -> OFF. On that transition ls_en=0 and ls_data=0.
- ERROR:
  - Outputs: iso_en=1, ls_en=0, ls_data=0, data_ready=0, pwr_ack=0, seq_err=1.
  - pwr_off_req -> OFF and clears seq_err. pwr_on_req is ignored while in ERROR.
- pwr_on_req is ignored in every state other than OFF.
- Invariant: iso_en=0 only in ACTIVE and DRAIN. ls_en=1 whenever iso_en=0.
- Timer width is clog2(max(SETTLE_CYCLES, TIMEOUT_CYCLES)). It saturates and never wraps.
- Async reset mid-sequence: immediately returns all outputs to reset values, including an asserted iso_en.

Decomposition:
- Package ls_pwr_pkg holds:
  - enum ls_seq_state_e (3-bit) with the encodings above
  - default constants LS_SETTLE_CYCLES_DEF and LS_TIMEOUT_CYCLES_DEF
- Sub-module: sync_2ff, a one-bit 2-flop synchronizer with asynchronous active-low reset. Instantiated twice.

Test Plan:
- Power-up, with SETTLE_CYCLES=8, supplies good from reset: pwr_on_req at cycle 0 -> WAIT_SUPPLY at cycle 1; ls_en=1 from SETTLE entry; iso_en falls, pwr_ack and data_ready rise exactly 8 cycles after SETTLE entry.
- Data in ACTIVE: data_valid with 0xA5, then 0x3C back-to-back -> ls_data=0xA5, then 0x3C on the following edges. With data_valid=0, ls_data holds 0x3C.
- Orderly power-down: pwr_off_req in ACTIVE -> 1 DRAIN cycle with data_ready=0; then iso_en=1 while ls_en stays 1 for 8 cycles; then ls_en=0, ls_data=0, state_o=0.
- Timeout: TIMEOUT_CYCLES=16, vdd_low_good_async held 0 -> ERROR after 16 cycles in WAIT_SUPPLY, seq_err=1. pwr_on_req is ignored; pwr_off_req returns to OFF with seq_err=0.
- Supply glitch in SETTLE: vdd_low_good_async low for 3 cycles at settle count 4 -> back to WAIT_SUPPLY, ls_en drops; the full 8-cycle settle repeats after good returns.
- Supply loss in ACTIVE plus mid-sequence reset: good drops -> ERROR, iso_en=1 and ls_data=0 within 2 synchronizer cycles plus 1. Asserting rst_n=0 mid-SETTLE forces iso_en=1 and ls_en=0 without a clock edge.
